// File: rtl/bundle_pack_serializer_pkg.sv
// rtl/bundle_pack_serializer_pkg.sv - widths, state type and reference packing for the bundle serializer
//
// Purpose : shared definitions for bundle_pack_serializer and its flatten helper.
// Contents: field widths (A_W/C_W/D_W/B_W), beat width OUT_W, derived TOTAL_W/BEATS/BEAT_W/HOLD_W,
//           the serializer state enum, and pack_bundle() returning the flattened word P.
package bundle_pack_pkg;

    localparam int A_W     = 10;
    localparam int C_W     = 1;
    localparam int D_W     = 20;
    localparam int B_W     = 11;
    localparam int OUT_W   = 16;

    localparam int TOTAL_W = A_W + 2 * (C_W + D_W) + B_W;
    localparam int BEATS   = (TOTAL_W + OUT_W - 1) / OUT_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Holding register is rounded up to whole beats; the pad bits stay zero.
    localparam int HOLD_W  = BEATS * OUT_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Flattened asUInt order: b in the LSBs, a in the MSBs.
    function automatic logic [TOTAL_W-1:0] pack_bundle(
        input logic [A_W-1:0] a,
        input logic [C_W-1:0] c_1,
        input logic [D_W-1:0] d_1,
        input logic [C_W-1:0] c_0,
        input logic [D_W-1:0] d_0,
        input logic [B_W-1:0] b
    );
        return {a, c_1, d_1, c_0, d_0, b};
    endfunction

endpackage

// File: rtl/bundle_pack_serializer_if.sv
// rtl/bundle_pack_serializer_if.sv - record-in / beat-out handshake bundle
//
// Purpose : groups the record input handshake and the beat output handshake.
// Signals : in_valid/in_ready + fields in_a, in_bar_c_0, in_bar_d_0, in_bar_c_1, in_bar_d_1, in_b;
//           out_valid/out_ready, out_data, out_last, out_beat.
// Modports: master - producer/consumer side driving records and accepting beats.
//           slave  - the serializer.
interface bundle_pack_serializer_if;
    import bundle_pack_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [A_W-1:0]    in_a;
    logic [C_W-1:0]    in_bar_c_0;
    logic [D_W-1:0]    in_bar_d_0;
    logic [C_W-1:0]    in_bar_c_1;
    logic [D_W-1:0]    in_bar_d_1;
    logic [B_W-1:0]    in_b;

    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic [BEAT_W-1:0] out_beat;

    modport master (
        output in_valid, in_a, in_bar_c_0, in_bar_d_0, in_bar_c_1, in_bar_d_1, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_beat
    );

    modport slave (
        input  in_valid, in_a, in_bar_c_0, in_bar_d_0, in_bar_c_1, in_bar_d_1, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last, out_beat
    );

endinterface

// File: rtl/bundle_pack_serializer_flatten.sv
// rtl/bundle_pack_serializer_flatten.sv - combinational flatten of a bundle record into P
//
// Purpose : builds P = {a, c_1, d_1, c_0, d_0, b} from pairwise groups.
// Ports   : a_i, c_1_i, d_1_i, c_0_i, d_0_i, b_i - record fields
//           p_o                                  - flattened word, TOTAL_W bits
module bundle_pack_flatten
    import bundle_pack_pkg::*;
(
    input  logic [A_W-1:0]     a_i,
    input  logic [C_W-1:0]     c_1_i,
    input  logic [D_W-1:0]     d_1_i,
    input  logic [C_W-1:0]     c_0_i,
    input  logic [D_W-1:0]     d_0_i,
    input  logic [B_W-1:0]     b_i,
    output logic [TOTAL_W-1:0] p_o
);

    logic [A_W+C_W-1:0]         g_a_c1;
    logic [D_W+C_W-1:0]         g_d1_c0;
    logic [D_W+B_W-1:0]         g_d0_b;
    logic [A_W+2*C_W+D_W-1:0]   g_hi;

    assign g_a_c1  = {a_i, c_1_i};
    assign g_d1_c0 = {d_1_i, c_0_i};
    assign g_d0_b  = {d_0_i, b_i};
    assign g_hi    = {g_a_c1, g_d1_c0};
    assign p_o     = {g_hi, g_d0_b};

endmodule

// File: rtl/bundle_pack_serializer.sv
// rtl/bundle_pack_serializer.sv - accepts one bundle record, emits it as OUT_W-bit beats LSB first
//
// Purpose : flattens each accepted record into P and streams BEATS beats of OUT_W bits.
//           Back-to-back records are accepted on the last beat of the previous one.
// Ports   : clock  - single clock, rising edge
//           reset  - synchronous, active-high
//           bus    - slave modport: record handshake in, beat handshake out
//           busy   - a record is held (state SEND)
module bundle_pack_serializer
    import bundle_pack_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    bundle_pack_serializer_if.slave   bus,
    output logic                      busy
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               last_q, last_d;

    logic [TOTAL_W-1:0] packed_w;
    logic [OUT_W-1:0]   hold_words [BEATS];
    logic [BEAT_W-1:0]  beat_inc;
    logic               accept;
    logic               advance;
    logic               finish;

    bundle_pack_flatten u_flatten (
        .a_i   (bus.in_a),
        .c_1_i (bus.in_bar_c_1),
        .d_1_i (bus.in_bar_d_1),
        .c_0_i (bus.in_bar_c_0),
        .d_0_i (bus.in_bar_d_0),
        .b_i   (bus.in_b),
        .p_o   (packed_w)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // Last beat consumed: stay in SEND only if a new record is taken now.
                if (bus.out_ready && last_q && !bus.in_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready depends combinationally on out_ready during the last beat so that
    // the next record can be taken without a bubble cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
            end
            SEND: begin
                bus.in_ready  = bus.out_ready & last_q;
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    assign accept   = bus.in_valid & bus.in_ready;
    assign advance  = (state_q == SEND) & bus.out_ready & ~last_q;
    assign finish   = (state_q == SEND) & bus.out_ready & last_q & ~bus.in_valid;
    assign beat_inc = beat_q + BEAT_W'(1);

    always_comb begin
        for (int k = 0; k < BEATS; k++) begin
            hold_words[k] = hold_q[k*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        hold_d = hold_q;
        beat_d = beat_q;
        data_d = data_q;
        last_d = last_q;
        if (accept) begin
            // Beat 0 comes straight from the flattened inputs so it is valid the
            // cycle after accept; later beats come from the holding register.
            hold_d = HOLD_W'(packed_w);
            beat_d = '0;
            data_d = packed_w[OUT_W-1:0];
            last_d = (BEATS == 1);
        end else if (advance) begin
            beat_d = beat_inc;
            data_d = hold_words[beat_inc];
            last_d = (beat_inc == LAST_BEAT);
        end else if (finish) begin
            beat_d = '0;
            data_d = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
            beat_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            beat_q <= beat_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign bus.out_data = data_q;
    assign bus.out_last = last_q;
    assign bus.out_beat = beat_q;

endmodule

// File: tb/tb_bundle_pack_serializer.sv
// tb/tb_bundle_pack_serializer.sv - self-checking bench for bundle_pack_serializer
module tb_bundle_pack_serializer;
    import bundle_pack_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          beat;
        logic        last;
    } beat_t;

    logic clock;
    logic reset;
    logic busy;

    bundle_pack_serializer_if bus ();

    bundle_pack_serializer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    beat_t       q[$];
    logic [15:0] cap[$];
    int          cap_cyc[$];
    int          acc_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: P built from the documented bit positions, split into 16-bit beats.
    function automatic logic [63:0] model_p(input logic [9:0] a, input logic c0, input logic [19:0] d0,
                                            input logic c1, input logic [19:0] d1, input logic [10:0] b);
        logic [63:0] p;
        p = 64'(b) | (64'(d0) << 11) | (64'(c0) << 31) | (64'(d1) << 32) | (64'(c1) << 52) | (64'(a) << 53);
        return p;
    endfunction

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic [1:0]  prev_beat  = '0;

    // Compare process: checks every cycle, then advances the model to the next edge.
    always @(negedge clock) begin
        logic exp_valid;
        logic exp_in_ready;
        logic [63:0] p;
        beat_t e;
        exp_valid    = (q.size() > 0);
        exp_in_ready = (q.size() == 0) || (bus.out_ready && q[0].last);
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(exp_valid));
        check("in_ready", 64'(bus.in_ready), 64'(exp_in_ready));
        if (exp_valid) begin
            check("out_data", 64'(bus.out_data), 64'(q[0].data));
            check("out_beat", 64'(bus.out_beat), 64'(q[0].beat));
            check("out_last", 64'(bus.out_last), 64'(q[0].last));
        end
        if (prev_stall && bus.out_valid) begin
            check("stall_data_stable", 64'(bus.out_data), 64'(prev_data));
            check("stall_beat_stable", 64'(bus.out_beat), 64'(prev_beat));
        end
        prev_stall = bus.out_valid && !bus.out_ready && !reset;
        prev_data  = bus.out_data;
        prev_beat  = bus.out_beat;

        if (reset) begin
            q.delete();
        end else begin
            if (exp_valid && bus.out_ready) begin
                cap.push_back(bus.out_data);
                cap_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (bus.in_valid && exp_in_ready) begin
                p = model_p(bus.in_a, bus.in_bar_c_0, bus.in_bar_d_0, bus.in_bar_c_1, bus.in_bar_d_1, bus.in_b);
                for (int k = 0; k < 4; k++) begin
                    e.data = p[k*16 +: 16];
                    e.beat = k;
                    e.last = (k == 3);
                    q.push_back(e);
                end
                acc_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic set_fields(input logic [9:0] a, input logic c0, input logic [19:0] d0,
                              input logic c1, input logic [19:0] d1, input logic [10:0] b);
        bus.in_a       = a;
        bus.in_bar_c_0 = c0;
        bus.in_bar_d_0 = d0;
        bus.in_bar_c_1 = c1;
        bus.in_bar_d_1 = d1;
        bus.in_b       = b;
    endtask

    task automatic scramble_fields();
        set_fields(10'($urandom), 1'($urandom), 20'($urandom), 1'($urandom), 20'($urandom), 11'($urandom));
    endtask

    // Entered and left at posedge+1; returns after the accepting edge.
    task automatic wait_accept(input string name);
        int c = 0;
        bit ok = 0;
        while (!ok && c < 30) begin
            @(negedge clock);
            if (bus.in_ready) ok = 1;
            @(posedge clock);
            #1;
            c++;
        end
        check({name, "_accept_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_cap(input int n, input string name);
        int c = 0;
        while (cap.size() < n && c < 60) begin
            @(posedge clock);
            #1;
            c++;
        end
        check({name, "_beats_timeout"}, 64'(cap.size() >= n), 64'd1);
    endtask

    task automatic run_record(input string name, input logic [9:0] a, input logic c0, input logic [19:0] d0,
                              input logic c1, input logic [19:0] d1, input logic [10:0] b,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        cap.delete();
        set_fields(a, c0, d0, c1, d1, b);
        bus.in_valid = 1'b1;
        wait_accept(name);
        bus.in_valid = 1'b0;
        scramble_fields();
        wait_cap(4, name);
        repeat (2) @(posedge clock);
        #1;
        check({name, "_count"}, 64'(cap.size()), 64'd4);
        if (cap.size() >= 4) begin
            check({name, "_b0"}, 64'(cap[0]), 64'(e0));
            check({name, "_b1"}, 64'(cap[1]), 64'(e1));
            check({name, "_b2"}, 64'(cap[2]), 64'(e2));
            check({name, "_b3"}, 64'(cap[3]), 64'(e3));
        end
    endtask

    task automatic send_pair(input logic [10:0] b1, input logic [9:0] a2);
        set_fields(10'h0, 1'b0, 20'h0, 1'b0, 20'h0, b1);
        bus.in_valid = 1'b1;
        wait_accept("pair_r1");
        set_fields(a2, 1'b0, 20'h0, 1'b0, 20'h0, 11'h0);
        wait_accept("pair_r2");
        bus.in_valid = 1'b0;
        scramble_fields();
    endtask

    initial begin
        // 1. Reset held 3 cycles with a valid record offered.
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_fields(10'h3FF, 1'b1, 20'hFFFFF, 1'b1, 20'hFFFFF, 11'h7FF);
        repeat (3) @(posedge clock);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_beat", 64'(bus.out_beat), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_no_beats", 64'(cap.size()), 64'd0);

        // 2-4. Single-field records.
        run_record("b_only",  10'h0,   1'b0, 20'h0,     1'b0, 20'h0, 11'h7FF, 16'h07FF, 16'h0000, 16'h0000, 16'h0000);
        run_record("a_only",  10'h3FF, 1'b0, 20'h0,     1'b0, 20'h0, 11'h0,   16'h0000, 16'h0000, 16'h0000, 16'h7FE0);
        run_record("d0_only", 10'h0,   1'b0, 20'hFFFFF, 1'b0, 20'h0, 11'h0,   16'hF800, 16'h7FFF, 16'h0000, 16'h0000);
        run_record("c_only",  10'h0,   1'b1, 20'h0,     1'b1, 20'h0, 11'h0,   16'h0000, 16'h8000, 16'h0000, 16'h0010);

        // 5. Backpressure 1,0,0,1,... on a mixed record.
        cap.delete();
        set_fields(10'h155, 1'b1, 20'hABCDE, 1'b0, 20'h12345, 11'h2AA);
        bus.in_valid = 1'b1;
        wait_accept("stall");
        bus.in_valid = 1'b0;
        scramble_fields();
        for (int i = 0; i < 40 && cap.size() < 4; i++) begin
            bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("stall_count", 64'(cap.size()), 64'd4);
        if (cap.size() >= 4) begin
            check("stall_b0", 64'(cap[0]), 64'hF2AA);
            check("stall_b1", 64'(cap[1]), 64'hD5E6);
            check("stall_b2", 64'(cap[2]), 64'h2345);
            check("stall_b3", 64'(cap[3]), 64'h2AA1);
        end

        // 6a. Back-to-back records, no bubble.
        cap.delete();
        cap_cyc.delete();
        acc_cyc.delete();
        send_pair(11'h001, 10'h001);
        wait_cap(8, "b2b");
        check("b2b_count", 64'(cap.size()), 64'd8);
        if (cap.size() >= 8 && acc_cyc.size() >= 2) begin
            check("b2b_contiguous", 64'(cap_cyc[7] - cap_cyc[0]), 64'd7);
            check("b2b_accept_on_last", 64'(acc_cyc[1]), 64'(cap_cyc[3]));
            check("b2b_r1_b0", 64'(cap[0]), 64'h0001);
            check("b2b_r1_b3", 64'(cap[3]), 64'h0000);
            check("b2b_r2_b0", 64'(cap[4]), 64'h0000);
            check("b2b_r2_b3", 64'(cap[7]), 64'h0020);
        end

        // 6b. Reset on beat 2 of the second record.
        repeat (2) @(posedge clock);
        #1;
        cap.delete();
        send_pair(11'h123, 10'h2AB);
        wait_cap(6, "rstmid");
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        check("rstmid_no_more_beats", 64'(cap.size()), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
